// File: rtl/sc_player_move_fsm.sv
// Frogger player controller: button-driven grid moves with edge clamping,
// hold-to-repeat, and ownership of lives, score and game state.
module sc_player_move_fsm #(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int START_COL  = 3,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 8,
    parameter int REPEAT_DLY = 20,
    parameter int REPEAT_PER = 8
) (
    input  logic                      SC_PLAYERMOVE_CLOCK_50,
    input  logic                      SC_PLAYERMOVE_RESET_InHigh,
    input  logic                      SC_PLAYERMOVE_startGame_InLow,
    input  logic                      SC_PLAYERMOVE_upButton_InLow,
    input  logic                      SC_PLAYERMOVE_downButton_InLow,
    input  logic                      SC_PLAYERMOVE_leftButton_InLow,
    input  logic                      SC_PLAYERMOVE_rightButton_InLow,
    input  logic                      SC_PLAYERMOVE_hit_InHigh,
    output logic [$clog2(ROWS)-1:0]   SC_PLAYERMOVE_row_Out,
    output logic [$clog2(COLS)-1:0]   SC_PLAYERMOVE_col_Out,
    output logic                      SC_PLAYERMOVE_move_Out,
    output logic                      SC_PLAYERMOVE_blocked_Out,
    output logic [1:0]                SC_PLAYERMOVE_dir_Out,
    output logic                      SC_PLAYERMOVE_win_Out,
    output logic [3:0]                SC_PLAYERMOVE_lives_Out,
    output logic [SCORE_W-1:0]        SC_PLAYERMOVE_score_Out,
    output logic                      SC_PLAYERMOVE_playing_Out,
    output logic                      SC_PLAYERMOVE_gameOver_Out
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_REL, S_READY, S_MOVE, S_HOLD, S_WIN, S_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        row_q, row_d, row_mv;
    logic [CW-1:0]        col_q, col_d, col_mv;
    logic [1:0]           dir_q, dir_d, pick;
    logic [3:0]           lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic                 rpt_q, rpt_d;
    logic                 move_q, move_d, blk_q, blk_d, win_q, win_d;
    logic                 play_q, play_d, over_q, over_d;
    logic                 up, dn, lf, rt, any_dir, all_rel, held;
    int                   thr;

    assign up = ~SC_PLAYERMOVE_upButton_InLow;
    assign dn = ~SC_PLAYERMOVE_downButton_InLow;
    assign lf = ~SC_PLAYERMOVE_leftButton_InLow;
    assign rt = ~SC_PLAYERMOVE_rightButton_InLow;
    assign any_dir = up | dn | lf | rt;
    assign all_rel = ~any_dir & SC_PLAYERMOVE_startGame_InLow;

    function automatic logic legal(input logic [1:0] d,
                                   input logic [RW-1:0] r,
                                   input logic [CW-1:0] c);
        unique case (d)
            2'd0:    return r < RW'(ROWS - 1);
            2'd1:    return r != '0;
            2'd2:    return c != '0;
            default: return c < CW'(COLS - 1);
        endcase
    endfunction

    always_comb begin
        pick = 2'd3;
        if (up)      pick = 2'd0;
        else if (dn) pick = 2'd1;
        else if (lf) pick = 2'd2;
        held = 1'b0;
        unique case (dir_q)
            2'd0:    held = up;
            2'd1:    held = dn;
            2'd2:    held = lf;
            default: held = rt;
        endcase
    end

    always_comb begin
        row_mv = row_q;
        col_mv = col_q;
        unique case (dir_q)
            2'd0:    row_mv = row_q + 1'b1;
            2'd1:    row_mv = row_q - 1'b1;
            2'd2:    col_mv = col_q - 1'b1;
            default: col_mv = col_q + 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        lives_d = lives_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        move_d  = 1'b0;
        blk_d   = 1'b0;
        win_d   = 1'b0;
        thr     = rpt_q ? REPEAT_PER : REPEAT_DLY;
        // A collision overrides whatever the playing state would do
        if (SC_PLAYERMOVE_hit_InHigh && play_q) begin
            row_d   = '0;
            col_d   = CW'(START_COL);
            lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
            state_d = (lives_q <= 4'd1) ? S_OVER : S_WAIT_REL;
        end else begin
            unique case (state_q)
                S_IDLE, S_OVER: begin
                    row_d = '0;
                    col_d = CW'(START_COL);
                    if (!SC_PLAYERMOVE_startGame_InLow) begin
                        lives_d = 4'(LIVES);
                        score_d = '0;
                        state_d = S_WAIT_REL;
                    end
                end
                S_WAIT_REL: begin
                    if (all_rel) state_d = S_READY;
                end
                S_READY: begin
                    if (any_dir) begin
                        dir_d   = pick;
                        move_d  = legal(pick, row_q, col_q);
                        blk_d   = ~legal(pick, row_q, col_q);
                        rpt_d   = 1'b0;
                        state_d = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (move_q) begin
                        row_d = row_mv;
                        col_d = col_mv;
                    end
                    if (move_q && row_mv == RW'(ROWS - 1)) begin
                        win_d   = 1'b1;
                        state_d = S_WIN;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // The MOVE cycle counts towards the repeat interval
                    if (!held) begin
                        state_d = all_rel ? S_READY : S_WAIT_REL;
                    end else if (REPEAT_DLY != 0 && int'(cnt_q) + 2 >= thr) begin
                        move_d  = legal(dir_q, row_q, col_q);
                        blk_d   = ~legal(dir_q, row_q, col_q);
                        rpt_d   = 1'b1;
                        state_d = S_MOVE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WIN: begin
                    score_d = (&score_q) ? score_q : score_q + 1'b1;
                    row_d   = '0;
                    col_d   = CW'(START_COL);
                    state_d = S_WAIT_REL;
                end
                default: state_d = S_IDLE;
            endcase
        end
        play_d = state_d == S_WAIT_REL || state_d == S_READY ||
                 state_d == S_MOVE || state_d == S_HOLD;
        over_d = state_d == S_OVER;
    end

    always_ff @(posedge SC_PLAYERMOVE_CLOCK_50) begin
        if (SC_PLAYERMOVE_RESET_InHigh) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= CW'(START_COL);
            dir_q   <= 2'd0;
            lives_q <= 4'(LIVES);
            score_q <= '0;
            cnt_q   <= '0;
            rpt_q   <= 1'b0;
            move_q  <= 1'b0;
            blk_q   <= 1'b0;
            win_q   <= 1'b0;
            play_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            lives_q <= lives_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            move_q  <= move_d;
            blk_q   <= blk_d;
            win_q   <= win_d;
            play_q  <= play_d;
            over_q  <= over_d;
        end
    end

    assign SC_PLAYERMOVE_row_Out      = row_q;
    assign SC_PLAYERMOVE_col_Out      = col_q;
    assign SC_PLAYERMOVE_move_Out     = move_q & ~SC_PLAYERMOVE_hit_InHigh;
    assign SC_PLAYERMOVE_blocked_Out  = blk_q & ~SC_PLAYERMOVE_hit_InHigh;
    assign SC_PLAYERMOVE_dir_Out      = dir_q;
    assign SC_PLAYERMOVE_win_Out      = win_q;
    assign SC_PLAYERMOVE_lives_Out    = lives_q;
    assign SC_PLAYERMOVE_score_Out    = score_q;
    assign SC_PLAYERMOVE_playing_Out  = play_q;
    assign SC_PLAYERMOVE_gameOver_Out = over_q;

endmodule

// File: tb/tb_sc_player_move_fsm.sv
// Bench for sc_player_move_fsm: directed game scenarios plus random
// presses checked against a press-level arithmetic model.
module tb_sc_player_move_fsm;
    localparam int COLS = 8, ROWS = 8, START_COL = 3, LIVES = 3;
    localparam int SCORE_W = 8, DLY = 4, PER = 2;

    logic clk = 0, rst = 1, start_n = 1;
    logic up_n = 1, dn_n = 1, lf_n = 1, rt_n = 1, hit = 0;
    logic [2:0] row, col;
    logic mv, blk, win, playing, over;
    logic [1:0] dir;
    logic [3:0] lives;
    logic [SCORE_W-1:0] score;

    int checks = 0, errors = 0;
    int tcnt, n_win;
    logic [63:0] mv_mask, blk_mask;
    int m_row, m_col, m_score, m_lives, m_dir;

    sc_player_move_fsm #(
        .COLS(COLS), .ROWS(ROWS), .START_COL(START_COL), .LIVES(LIVES),
        .SCORE_W(SCORE_W), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .SC_PLAYERMOVE_CLOCK_50(clk),
        .SC_PLAYERMOVE_RESET_InHigh(rst),
        .SC_PLAYERMOVE_startGame_InLow(start_n),
        .SC_PLAYERMOVE_upButton_InLow(up_n),
        .SC_PLAYERMOVE_downButton_InLow(dn_n),
        .SC_PLAYERMOVE_leftButton_InLow(lf_n),
        .SC_PLAYERMOVE_rightButton_InLow(rt_n),
        .SC_PLAYERMOVE_hit_InHigh(hit),
        .SC_PLAYERMOVE_row_Out(row),
        .SC_PLAYERMOVE_col_Out(col),
        .SC_PLAYERMOVE_move_Out(mv),
        .SC_PLAYERMOVE_blocked_Out(blk),
        .SC_PLAYERMOVE_dir_Out(dir),
        .SC_PLAYERMOVE_win_Out(win),
        .SC_PLAYERMOVE_lives_Out(lives),
        .SC_PLAYERMOVE_score_Out(score),
        .SC_PLAYERMOVE_playing_Out(playing),
        .SC_PLAYERMOVE_gameOver_Out(over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tcnt++;
        if (mv)  mv_mask  |= 64'd1 << tcnt;
        if (blk) blk_mask |= 64'd1 << tcnt;
        if (win) n_win++;
    endtask

    task automatic clr();
        tcnt = 0; n_win = 0; mv_mask = '0; blk_mask = '0;
    endtask

    task automatic set_btn(input int d, input logic v);
        case (d)
            0: up_n = v;
            1: dn_n = v;
            2: lf_n = v;
            default: rt_n = v;
        endcase
    endtask

    function automatic bit m_legal(input int d);
        case (d)
            0: return m_row < ROWS - 1;
            1: return m_row > 0;
            2: return m_col > 0;
            default: return m_col < COLS - 1;
        endcase
    endfunction

    // Hold for h cycles: attempts land at press cycles 1, 1+DLY, then every PER
    task automatic press(input int d, input int h, input int g);
        logic [63:0] emv, eblk;
        int ewin, k, st;
        emv = '0; eblk = '0; ewin = 0; k = 1; st = DLY;
        while (k <= h) begin
            if (m_legal(d)) begin
                emv |= 64'd1 << k;
                case (d)
                    0: m_row++;
                    1: m_row--;
                    2: m_col--;
                    default: m_col++;
                endcase
                if (m_row == ROWS - 1) begin
                    ewin = 1;
                    if (m_score < (1 << SCORE_W) - 1) m_score++;
                    m_row = 0;
                    m_col = START_COL;
                    break;
                end
            end else begin
                eblk |= 64'd1 << k;
            end
            if (DLY == 0) break;
            k += st;
            st = PER;
        end
        m_dir = d;
        clr();
        set_btn(d, 1'b0);
        repeat (h) tick();
        set_btn(d, 1'b1);
        repeat (g) tick();
        chk("move_times", mv_mask, emv);
        chk("blocked_times", blk_mask, eblk);
        chk("win_count", n_win, ewin);
        chk("row", row, m_row);
        chk("col", col, m_col);
        chk("score", score, m_score);
        chk("dir", dir, m_dir);
    endtask

    initial begin
        clr();
        repeat (3) tick();
        chk("rst_row", row, 0);
        chk("rst_col", col, START_COL);
        chk("rst_lives", lives, LIVES);
        chk("rst_score", score, 0);
        chk("rst_dir", dir, 0);
        chk("rst_playing", playing, 0);
        chk("rst_over", over, 0);
        chk("rst_strobes", {mv, blk, win}, 0);
        rst = 0;
        repeat (2) tick();
        chk("idle_playing", playing, 0);

        start_n = 0; tick(); start_n = 1; repeat (2) tick();
        chk("start_playing", playing, 1);
        chk("start_lives", lives, LIVES);
        chk("start_score", score, 0);
        m_row = 0; m_col = START_COL; m_score = 0; m_lives = LIVES; m_dir = 0;

        press(1, 1, 4);
        press(0, 1, 4);
        press(1, 1, 4);
        repeat (3) press(2, 1, 4);
        press(2, 8, 4);
        repeat (3) press(3, 1, 4);
        press(3, 12, 4);
        repeat (7) press(0, 1, 4);
        chk("win_score", score, 1);
        repeat (6) press(0, 1, 4);
        press(0, 10, 4);
        chk("held_win_score", score, 2);

        // hit and up together in READY
        press(0, 1, 4);
        clr();
        up_n = 0; hit = 1; tick();
        up_n = 1; hit = 0; repeat (3) tick();
        m_lives--; m_row = 0; m_col = START_COL;
        chk("hitrdy_strobes", mv_mask | blk_mask, 0);
        chk("hitrdy_row", row, m_row);
        chk("hitrdy_col", col, m_col);
        chk("hitrdy_lives", lives, m_lives);

        // hit while moving from row 6 to the goal
        repeat (6) press(0, 1, 4);
        clr();
        up_n = 0;
        @(posedge clk); #1;
        hit = 1; up_n = 1;
        repeat (2) tick();
        hit = 0;
        repeat (3) tick();
        m_lives--; m_row = 0; m_col = START_COL;
        chk("hitmv_strobes", mv_mask | blk_mask, 0);
        chk("hitmv_win", n_win, 0);
        chk("hitmv_row", row, m_row);
        chk("hitmv_col", col, m_col);
        chk("hitmv_lives", lives, m_lives);
        chk("hitmv_score", score, m_score);

        hit = 1; tick(); hit = 0; tick();
        chk("dead_lives", lives, 0);
        chk("dead_over", over, 1);
        chk("dead_playing", playing, 0);
        clr();
        up_n = 0; repeat (2) tick(); up_n = 1; repeat (3) tick();
        chk("over_ignore", mv_mask | blk_mask, 0);
        chk("over_row", row, 0);
        chk("over_stays", over, 1);

        start_n = 0; tick(); start_n = 1; repeat (2) tick();
        m_lives = LIVES; m_score = 0;
        chk("restart_lives", lives, m_lives);
        chk("restart_score", score, 0);
        chk("restart_playing", playing, 1);
        chk("restart_over", over, 0);

        for (int i = 0; i < 24; i++)
            press(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 4);

        // synchronous reset while holding a direction
        clr();
        set_btn(m_col > 0 ? 2 : 3, 1'b0);
        repeat (2) tick();
        rst = 1; tick();
        chk("mrst_row", row, 0);
        chk("mrst_col", col, START_COL);
        chk("mrst_score", score, 0);
        chk("mrst_lives", lives, LIVES);
        chk("mrst_strobes", {mv, blk, win}, 0);
        chk("mrst_playing", playing, 0);
        chk("mrst_over", over, 0);
        lf_n = 1; rt_n = 1; rst = 0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
